// File: rtl/filter_ctrl_pkg.sv
// rtl/filter_ctrl_pkg.sv - shared types and constants for the filter-mode control path
//
// Purpose: common definitions for the mode counter and the mode LED blinker.
// Contents:
//   MODE_W        width of the filter-mode value
//   blink_state_t blinker FSM states
//   max3          largest of three durations, used to size the phase timer
package filter_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mode_led_blinker_if.sv
// rtl/mode_led_blinker_if.sv - mode/enable inputs and LED status outputs of the blinker
//
// Purpose: bundles the blinker's functional signals.
// Signals:
//   i_mode          current filter mode (0..3)
//   i_enable        1 = indicator active, 0 = LED forced dark
//   o_led           LED drive, 1 = lit
//   o_busy          1 while a burst or its gap is in progress
//   o_mode_latched  mode value being displayed
// Modports: master drives mode/enable (mode counter side), slave is the blinker.
interface mode_led_blinker_if;
  import filter_ctrl_pkg::*;

  logic [MODE_W-1:0] i_mode;
  logic              i_enable;
  logic              o_led;
  logic              o_busy;
  logic [MODE_W-1:0] o_mode_latched;

  modport master (
    output i_mode,
    output i_enable,
    input  o_led,
    input  o_busy,
    input  o_mode_latched
  );

  modport slave (
    input  i_mode,
    input  i_enable,
    output o_led,
    output o_busy,
    output o_mode_latched
  );

endinterface

// File: rtl/mode_led_blinker_phase_timer.sv
// rtl/mode_led_blinker_phase_timer.sv - loadable down-counter timing one blink phase
//
// Purpose: counts down from a loaded value and flags when it reads zero.
// Ports:
//   i_clk    clock
//   i_rst    synchronous reset, active-low (count returns to 0)
//   i_load   load i_value on this edge (takes priority over counting)
//   i_value  load value, phase duration minus one
//   o_done   1 while the count reads 0, i.e. last cycle of the phase
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Holds at zero rather than wrapping; every phase change reloads it.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_done = (count_q == '0);

endmodule

// File: rtl/mode_led_blinker.sv
// rtl/mode_led_blinker.sv - reports the selected filter mode as (mode+1) LED blinks
//
// Purpose: on a mode change (or re-enable) shows the mode as a burst of
// (mode+1) blinks followed by a dark gap; optionally repeats the burst.
// Ports:
//   i_clk   clock
//   i_rst   synchronous reset, active-low
//   bus     mode_led_blinker_if.slave: i_mode, i_enable in; o_led, o_busy,
//           o_mode_latched out (all outputs registered)
// Parameters:
//   ON_CYCLES / OFF_CYCLES / GAP_CYCLES  phase lengths in i_clk cycles (>= 1)
//   REPEAT                               1 = re-issue the burst after each gap
module mode_led_blinker
  import filter_ctrl_pkg::*;
#(
  parameter int   ON_CYCLES  = 12_500_000,
  parameter int   OFF_CYCLES = 12_500_000,
  parameter int   GAP_CYCLES = 50_000_000,
  parameter logic REPEAT     = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mode_led_blinker_if.slave   bus
);

  localparam int TMR_W = $clog2(max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES) + 1);

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  blink_state_t      state_q, state_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic [MODE_W-1:0] mode_lat_q, mode_lat_d;
  logic [MODE_W-1:0] prev_mode_q, prev_mode_d;
  logic              en_prev_q, en_prev_d;
  logic              armed_q, armed_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_done;
  logic              trigger;

  phase_timer #(
    .WIDTH (TMR_W)
  ) u_phase_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (tmr_load),
    .i_value (tmr_value),
    .o_done  (tmr_done)
  );

  // armed_q is low for the first edge after reset: that edge only samples
  // mode/enable into the history registers, so a mode held across reset
  // does not look like a change and no blink appears until a real trigger.
  assign trigger = armed_q && bus.i_enable &&
                   ((bus.i_mode != prev_mode_q) || !en_prev_q);

  always_comb begin
    state_d     = state_q;
    mode_lat_d  = mode_lat_q;
    cnt_d       = cnt_q;
    tmr_load    = 1'b0;
    tmr_value   = ON_LOAD;
    // History registers track the inputs every cycle, even while disabled,
    // so changes made while dark never fire later.
    prev_mode_d = bus.i_mode;
    en_prev_d   = bus.i_enable;
    armed_d     = 1'b1;

    if (!bus.i_enable) begin
      // Disable wins over a simultaneous trigger.
      state_d = IDLE;
    end else if (trigger) begin
      // Restart from any state, including mid-burst; no dark cycle inserted.
      mode_lat_d = bus.i_mode;
      cnt_d      = 2'd0;
      state_d    = ON;
      tmr_load   = 1'b1;
      tmr_value  = ON_LOAD;
    end else begin
      case (state_q)
        ON: begin
          if (tmr_done) begin
            tmr_load = 1'b1;
            if (cnt_q == mode_lat_q) begin
              state_d   = GAP;
              tmr_value = GAP_LOAD;
            end else begin
              state_d   = OFF;
              tmr_value = OFF_LOAD;
              cnt_d     = cnt_q + 2'd1;
            end
          end
        end
        OFF: begin
          if (tmr_done) begin
            state_d   = ON;
            tmr_load  = 1'b1;
            tmr_value = ON_LOAD;
          end
        end
        GAP: begin
          if (tmr_done) begin
            if (REPEAT) begin
              state_d   = ON;
              cnt_d     = 2'd0;
              tmr_load  = 1'b1;
              tmr_value = ON_LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs registered alongside the state so they change on the same edge.
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      mode_lat_q  <= '0;
      prev_mode_q <= '0;
      en_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      mode_lat_q  <= mode_lat_d;
      prev_mode_q <= prev_mode_d;
      en_prev_q   <= en_prev_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o_led          = led_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_mode_latched = mode_lat_q;

endmodule

// File: tb/tb_mode_led_blinker.sv
// tb/tb_mode_led_blinker.sv - scoreboard bench for mode_led_blinker (one-shot and repeat instances)
module tb_mode_led_blinker;

  typedef struct {
    logic       led;
    logic       busy;
    logic [1:0] mode;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  exp_t q0[$];
  exp_t q1[$];

  mode_led_blinker_if bus0 ();
  mode_led_blinker_if bus1 ();

  mode_led_blinker #(
    .ON_CYCLES  (3),
    .OFF_CYCLES (2),
    .GAP_CYCLES (5),
    .REPEAT     (1'b0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  mode_led_blinker #(
    .ON_CYCLES  (3),
    .OFF_CYCLES (2),
    .GAP_CYCLES (5),
    .REPEAT     (1'b1)
  ) dut_rep (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic push0(input logic led, input logic busy, input logic [1:0] mode, input int n);
    exp_t e;
    e.led = led; e.busy = busy; e.mode = mode;
    for (int i = 0; i < n; i++) q0.push_back(e);
  endtask

  task automatic push1(input logic led, input logic busy, input logic [1:0] mode, input int n);
    exp_t e;
    e.led = led; e.busy = busy; e.mode = mode;
    for (int i = 0; i < n; i++) q1.push_back(e);
  endtask

  // Expected trace of a full burst for mode m: (m+1) x ON3, m x OFF2, GAP5.
  task automatic push_burst(input logic [1:0] m);
    for (int b = 0; b <= int'(m); b++) begin
      push0(1'b1, 1'b1, m, 3);
      if (b < int'(m)) push0(1'b0, 1'b1, m, 2);
    end
    push0(1'b0, 1'b1, m, 5);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("led", int'(bus0.o_led), int'(e.led));
      check("busy", int'(bus0.o_busy), int'(e.busy));
      check("mode_latched", int'(bus0.o_mode_latched), int'(e.mode));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("rep_led", int'(bus1.o_led), int'(e.led));
      check("rep_busy", int'(bus1.o_busy), int'(e.busy));
      check("rep_mode_latched", int'(bus1.o_mode_latched), int'(e.mode));
    end
  endtask

  task automatic drain();
    while (q0.size() > 0 || q1.size() > 0) tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus0.i_mode = 2'd0; bus0.i_enable = 1'b1;
    bus1.i_mode = 2'd0; bus1.i_enable = 1'b1;

    // Reset state
    tick();
    push0(1'b0, 1'b0, 2'd0, 2); push1(1'b0, 1'b0, 2'd0, 2);
    drain();
    rst = 1'b1;
    push0(1'b0, 1'b0, 2'd0, 3); push1(1'b0, 1'b0, 2'd0, 3);
    drain();

    // 0 -> 2: 111 00 111 00 111 00000, then idle
    bus0.i_mode = 2'd2;
    push_burst(2'd2);
    push0(1'b0, 1'b0, 2'd2, 3);
    drain();

    // 2 -> 3: four blinks; 3 -> 0: one blink
    bus0.i_mode = 2'd3;
    push_burst(2'd3);
    push0(1'b0, 1'b0, 2'd3, 2);
    drain();
    bus0.i_mode = 2'd0;
    push_burst(2'd0);
    push0(1'b0, 1'b0, 2'd0, 2);
    drain();

    // 0 -> 1, then 1 -> 2 during the second ON phase: run restarts, no more mode-1 blinks
    bus0.i_mode = 2'd1;
    push0(1'b1, 1'b1, 2'd1, 3);
    push0(1'b0, 1'b1, 2'd1, 2);
    push0(1'b1, 1'b1, 2'd1, 1);
    drain();
    bus0.i_mode = 2'd2;
    push_burst(2'd2);
    push0(1'b0, 1'b0, 2'd2, 3);
    drain();

    // Disable mid-burst, mode 1 -> 3 while disabled, re-enable fires one mode-3 burst
    bus0.i_mode = 2'd1;
    push0(1'b1, 1'b1, 2'd1, 3);
    push0(1'b0, 1'b1, 2'd1, 1);
    drain();
    bus0.i_enable = 1'b0;
    push0(1'b0, 1'b0, 2'd1, 1);
    drain();
    bus0.i_mode = 2'd3;
    push0(1'b0, 1'b0, 2'd1, 4);
    drain();
    bus0.i_enable = 1'b1;
    push_burst(2'd3);
    push0(1'b0, 1'b0, 2'd3, 3);
    drain();

    // Mode change and disable on the same edge: disable wins
    bus0.i_mode = 2'd0;
    bus0.i_enable = 1'b0;
    push0(1'b0, 1'b0, 2'd3, 3);
    drain();
    bus0.i_enable = 1'b1;
    push_burst(2'd0);
    push0(1'b0, 1'b0, 2'd0, 2);
    drain();

    // Reset during an OFF phase of a mode-2 burst, then 100 dark cycles
    bus0.i_mode = 2'd2;
    push0(1'b1, 1'b1, 2'd2, 3);
    push0(1'b0, 1'b1, 2'd2, 1);
    drain();
    rst = 1'b0;
    push0(1'b0, 1'b0, 2'd0, 2);
    drain();
    rst = 1'b1;
    push0(1'b0, 1'b0, 2'd0, 100);
    drain();

    // REPEAT instance: 0 -> 1 gives 111 00 111 00000 back to back
    bus1.i_mode = 2'd1;
    for (int r = 0; r < 3; r++) begin
      push1(1'b1, 1'b1, 2'd1, 3);
      push1(1'b0, 1'b1, 2'd1, 2);
      push1(1'b1, 1'b1, 2'd1, 3);
      push1(1'b0, 1'b1, 2'd1, 5);
    end
    drain();
    bus1.i_enable = 1'b0;
    push1(1'b0, 1'b0, 2'd1, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
